ddram_burst_reader: RTL and testbench
=====================================

Name: ddram_burst_reader

Overview:
Per-requestor read front-end for the DDR3 arbiter. Each core's splat reader and the coordinator's header reader instantiate one.
- Accepts a linear read command (base word address, word count).
- Splits the command into bursts of at most MAX_BURST words and drives one arbiter requestor read port.
- Buffers returned words in a FIFO and streams them to the consumer with valid/ready.
- Paces issue so a burst is never launched without FIFO room, because the DDR read data path has no backpressure.

Parameters:
- MAX_BURST, 16: maximum words per DDR burst. Range 1..255.
- FIFO_DEPTH, 32: output FIFO depth in 64-bit words. Power of 2, must be >= MAX_BURST.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  29  start word address.
- cmd_len  in  16  word count; 0 = no-op.
- out_data  out  64  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pop.
- busy  out  1  command in progress or FIFO not empty.
- done  out  1  one-cycle pulse when the last word of a command has been written into the FIFO.
- err  out  1  sticky: rd_data_valid arrived outside WAIT_DATA. Cleared only by reset.
- rd_addr  out  29  to arbiter.
- rd_burstcnt  out  8  to arbiter.
- rd_req  out  1  to arbiter.
- rd_ack  in  1  from arbiter.
- rd_data  in  64  from arbiter.
- rd_data_valid  in  1  from arbiter.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, rd_req=0, rd_addr=0, rd_burstcnt=0, out_valid=0, busy=0, done=0, err=0, FIFO empty, all counters 0.
- Command accept: on cmd_valid&&cmd_ready, latch cur_addr=cmd_addr and remain=cmd_len.
  - cmd_len=0: done pulses the next cycle; state stays IDLE; no DDR request.
  - Otherwise go to ISSUE.
- ISSUE:
  - blen = min(remain, MAX_BURST), computed from registered values.
  - rd_req is asserted only when (FIFO_DEPTH - fifo_count) >= blen; otherwise wait in ISSUE with rd_req=0.
  - rd_addr=cur_addr and rd_burstcnt=blen are registered on ISSUE entry.
  - Once rd_req is asserted, it stays high until rd_ack (level request; the arbiter may delay the grant arbitrarily).
  - On rd_ack: rd_req drops the same edge, wcnt=0, go to WAIT_DATA.
  - If rd_ack and rd_data_valid occur in the same cycle, that word is counted (wcnt=1).
- WAIT_DATA:
  - rd_addr and rd_burstcnt stay stable until the last word arrives. The arbiter muxes burstcnt during data return.
  - Each rd_data_valid pushes rd_data into the FIFO and increments wcnt.
  - On the word where wcnt+1==blen:
    - cur_addr += blen, modulo 2^29 (wraps silently).
    - remain -= blen.
    - If new remain==0: done pulses, go to IDLE. Otherwise go to ISSUE.
  - Minimum gap between bursts: 1 cycle (ISSUE re-evaluation).
- FIFO behaviour:
  - Room is guaranteed at issue time and only one burst is ever outstanding, so overflow is impossible.
  - First-word fall-through: out_data is valid in the same cycle out_valid is high.
  - Simultaneous push and pop leave the count unchanged.
  - Push into an empty FIFO gives out_valid=1 on the next cycle (latency rd_data_valid -> out_valid = 1 clk).
  - Pop while empty is ignored.
- rd_data_valid in IDLE or ISSUE: the word is dropped and err is set.
- busy = (state!=IDLE) || out_valid.
- Reset mid-burst:
  - Everything is cleared and FIFO contents are discarded.
  - The arbiter must be reset in the same cycle, so no stray burst remains outstanding.

Optional Feature:
- Macro: DDRAM_BURST_READER_STATS_EN.
- Defined adds these outputs:
  - stat_bursts[31:0]: count of rd_ack.
  - stat_words[31:0]: count of accepted rd_data_valid.
  - stat_wait_cycles[31:0]: cycles with rd_req=1 && !rd_ack (arbiter contention).
  - stat_stall_cycles[31:0]: cycles in ISSUE with rd_req=0 because of FIFO space.
  - All counters saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: these ports and their logic are absent. Functional behaviour is identical either way.

Decomposition:
- Package ddram_pkg:
  - DDR_AW=29, DDR_DW=64, DDR_BCW=8.
  - typedef enum logic [1:0] {BR_IDLE, BR_ISSUE, BR_WAIT_DATA} br_state_t.
- One sub-module: sync_fifo_fwft.
  - Parameters: WIDTH, DEPTH.
  - Outputs: count, empty, full.
  - Push/pop as above; reused by other DDR clients.

Test Plan:
- cmd addr=0x100, len=40, MAX_BURST=16, out_ready=1, ack after 3 cycles -> bursts (0x100,16), (0x110,16), (0x120,8); 40 words in order; one done pulse after the 40th word.
- out_ready=0, FIFO_DEPTH=32, len=48 -> two 16-word bursts, then rd_req stays 0. Raising out_ready for 16 pops -> third burst issued; err stays 0.
- len=0 -> done pulses 1 cycle after accept; rd_req never asserted; cmd_ready stays 1.
- addr=0x1FFFFFF8, len=16, MAX_BURST=8 -> second burst at rd_addr=0x00000000.
- rd_ack and first rd_data_valid in the same cycle, burstcnt=4 -> exactly 4 words pushed; done on the 4th word. A stray rd_data_valid in IDLE sets err=1.
- Assert reset for 1 cycle mid-WAIT_DATA (arbiter also reset) -> all outputs at reset values next cycle; a new cmd is then accepted and completes normally.

Source files
------------

// File: rtl/ddram_pkg.sv
// Shared DDR3 arbiter client definitions: bus widths, burst reader state encoding
// and the burst-length helper used by every read client.
package ddram_pkg;

  localparam int DDR_AW  = 29;
  localparam int DDR_DW  = 64;
  localparam int DDR_BCW = 8;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_ISSUE,
    BR_WAIT_DATA
  } br_state_t;

  function automatic logic [DDR_BCW-1:0] burst_len(input logic [15:0] remain,
                                                   input int max_burst);
    if (int'(remain) < max_burst) return remain[DDR_BCW-1:0];
    else return DDR_BCW'(max_burst);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO shared by the DDR read clients.
// Push while full and pop while empty are ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddram_burst_reader.sv
// Per-requestor DDR3 read front-end: splits a linear read into bursts, paces them
// on FIFO room and streams words out. Optional counters: DDRAM_BURST_READER_STATS_EN.
module ddram_burst_reader
  import ddram_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DDR_AW-1:0]  cmd_addr,
  input  logic [15:0]        cmd_len,
  output logic [DDR_DW-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DDR_AW-1:0]  rd_addr,
  output logic [DDR_BCW-1:0] rd_burstcnt,
  output logic               rd_req,
  input  logic               rd_ack,
  input  logic [DDR_DW-1:0]  rd_data,
  input  logic               rd_data_valid
`ifdef DDRAM_BURST_READER_STATS_EN
  ,
  output logic [31:0]        stat_bursts,
  output logic [31:0]        stat_words,
  output logic [31:0]        stat_wait_cycles,
  output logic [31:0]        stat_stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  br_state_t          state;
  br_state_t          next_state;
  logic [DDR_AW-1:0]  cur_addr;
  logic [15:0]        remain;
  logic [DDR_BCW-1:0] wcnt;
  logic [DDR_BCW-1:0] blen;
  logic [DDR_BCW:0]   wnext;
  logic [15:0]        new_remain;
  logic [DDR_AW-1:0]  new_addr;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               room_ok;
  logic               ack_ok;
  logic               push;
  logic               last_word;
  logic               bad_data;
  logic               done_next;

  // Only one burst is ever outstanding, so room checked here cannot shrink before
  // the data returns; a word arriving together with the grant belongs to the burst.
  always_comb begin
    blen       = burst_len(remain, MAX_BURST);
    room_ok    = (FIFO_DEPTH - int'(fifo_count)) >= int'(blen);
    ack_ok     = (state == BR_ISSUE) && room_ok && rd_ack;
    push       = rd_data_valid && ((state == BR_WAIT_DATA) || ack_ok);
    bad_data   = rd_data_valid && !push;
    wnext      = (state == BR_WAIT_DATA) ? ({1'b0, wcnt} + (DDR_BCW+1)'(1))
                                         : (DDR_BCW+1)'(1);
    last_word  = push && (wnext == {1'b0, blen});
    new_remain = remain - 16'(blen);
    new_addr   = cur_addr + DDR_AW'(blen);
  end

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    cmd_ready  = 1'b0;
    rd_req     = 1'b0;
    case (state)
      BR_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == 16'd0) done_next  = 1'b1;
          else                  next_state = BR_ISSUE;
        end
      end
      BR_ISSUE: begin
        rd_req = room_ok;
        if (ack_ok) next_state = BR_WAIT_DATA;
      end
      BR_WAIT_DATA: next_state = BR_WAIT_DATA;
      default:      next_state = BR_IDLE;
    endcase
    if (last_word) begin
      done_next  = (new_remain == 16'd0);
      next_state = (new_remain == 16'd0) ? BR_IDLE : BR_ISSUE;
    end
  end

  // rd_addr/rd_burstcnt load only when a burst is set up, so they hold steady
  // through the grant and the whole data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BR_IDLE;
      cur_addr    <= '0;
      remain      <= '0;
      wcnt        <= '0;
      rd_addr     <= '0;
      rd_burstcnt <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_next;
      if (bad_data) err <= 1'b1;
      if (state == BR_IDLE && cmd_valid) begin
        cur_addr    <= cmd_addr;
        remain      <= cmd_len;
        rd_addr     <= cmd_addr;
        rd_burstcnt <= burst_len(cmd_len, MAX_BURST);
      end else if (last_word) begin
        cur_addr    <= new_addr;
        remain      <= new_remain;
        rd_addr     <= new_addr;
        rd_burstcnt <= burst_len(new_remain, MAX_BURST);
        wcnt        <= '0;
      end else if (push) begin
        wcnt <= wnext[DDR_BCW-1:0];
      end else if (ack_ok) begin
        wcnt <= '0;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DDR_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push && !fifo_full),
    .push_data (rd_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state != BR_IDLE) || out_valid;

`ifdef DDRAM_BURST_READER_STATS_EN
  // Saturating counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bursts       <= '0;
      stat_words        <= '0;
      stat_wait_cycles  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (ack_ok && stat_bursts != '1)
        stat_bursts <= stat_bursts + 32'd1;
      if (push && stat_words != '1)
        stat_words <= stat_words + 32'd1;
      if (rd_req && !rd_ack && stat_wait_cycles != '1)
        stat_wait_cycles <= stat_wait_cycles + 32'd1;
      if (state == BR_ISSUE && !rd_req && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddram_burst_reader.sv
// Directed self-checking bench for ddram_burst_reader (MAX_BURST=16, FIFO_DEPTH=32)
// with a hand-driven arbiter and a scoreboard queue on the output stream.
module tb_ddram_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [28:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [28:0] rd_addr;
  logic [7:0]  rd_burstcnt;
  logic        rd_req;
  logic        rd_ack;
  logic [63:0] rd_data;
  logic        rd_data_valid;
`ifdef DDRAM_BURST_READER_STATS_EN
  logic [31:0] stat_bursts;
  logic [31:0] stat_words;
  logic [31:0] stat_wait_cycles;
  logic [31:0] stat_stall_cycles;
`endif

  int assert_count = 0;
  int fail_count   = 0;
  int done_pulses  = 0;
  bit req_seen     = 1'b0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  ddram_burst_reader #(
    .MAX_BURST  (16),
    .FIFO_DEPTH (32)
  ) dut (
`ifdef DDRAM_BURST_READER_STATS_EN
    .stat_bursts       (stat_bursts),
    .stat_words        (stat_words),
    .stat_wait_cycles  (stat_wait_cycles),
    .stat_stall_cycles (stat_stall_cycles),
`endif
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rd_addr       (rd_addr),
    .rd_burstcnt   (rd_burstcnt),
    .rd_req        (rd_req),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wordOf(input logic [28:0] a);
    return {16'hA5C3, 19'd0, a};
  endfunction

  // Output stream scoreboard and event monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (rd_req) req_seen = 1'b1;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("pop_underflow", 64'(exp_q.size()), 64'd1);
      else checkOutput("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [28:0] addr, input logic [15:0] len);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    checkOutput("cmd_ready_before", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Plays the arbiter for one burst: wait for the request, grant after a delay,
  // then return n_words words back to back (optionally the first with the grant).
  task automatic serveBurst(input logic [28:0] exp_addr, input logic [7:0] exp_cnt,
                            input int ack_delay, input bit same_cycle,
                            input bit track, input int n_words);
    int waited = 0;
    int k = 0;
    while (!rd_req && waited < 300) begin
      tick();
      waited++;
    end
    checkOutput("rd_req_seen", 64'(rd_req), 64'd1);
    checkOutput("rd_addr", 64'(rd_addr), 64'(exp_addr));
    checkOutput("rd_burstcnt", 64'(rd_burstcnt), 64'(exp_cnt));
    repeat (ack_delay) tick();
    checkOutput("rd_req_held", 64'(rd_req), 64'd1);
    rd_ack = 1'b1;
    if (same_cycle) begin
      rd_data_valid = 1'b1;
      rd_data = wordOf(exp_addr);
      if (track) exp_q.push_back(rd_data);
      k = 1;
    end
    tick();
    rd_ack = 1'b0;
    rd_data_valid = 1'b0;
    checkOutput("rd_req_drop", 64'(rd_req), 64'd0);
    while (k < n_words) begin
      checkOutput("rd_addr_stable", 64'(rd_addr), 64'(exp_addr));
      rd_data_valid = 1'b1;
      rd_data = wordOf(exp_addr + 29'(k));
      if (track) exp_q.push_back(rd_data);
      tick();
      k++;
    end
    rd_data_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (out_valid && n < 300) begin
      tick();
      n++;
    end
    checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    checkOutput({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    checkOutput({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    checkOutput({tag, "_rd_burstcnt"}, 64'(rd_burstcnt), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b1;
    rd_ack = 1'b0;
    rd_data = '0;
    rd_data_valid = 1'b0;
    repeat (2) tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    $display("[TB] test 1: 40 words from 0x100");
    d0 = done_pulses;
    applyStimulus(29'h100, 16'd40);
    checkOutput("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    serveBurst(29'h100, 8'd16, 3, 1'b0, 1'b1, 16);
    checkOutput("t1_done_early", 64'(done), 64'd0);
    serveBurst(29'h110, 8'd16, 3, 1'b0, 1'b1, 16);
    serveBurst(29'h120, 8'd8, 3, 1'b0, 1'b1, 8);
    checkOutput("t1_done", 64'(done), 64'd1);
    tick();
    checkOutput("t1_done_once", 64'(done), 64'd0);
    waitDrain();
    checkOutput("t1_done_count", 64'(done_pulses - d0), 64'd1);
    checkOutput("t1_err", 64'(err), 64'd0);

    $display("[TB] test 2: backpressure pacing, 48 words");
    out_ready = 1'b0;
    applyStimulus(29'h200, 16'd48);
    serveBurst(29'h200, 8'd16, 1, 1'b0, 1'b1, 16);
    serveBurst(29'h210, 8'd16, 1, 1'b0, 1'b1, 16);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_req_stalled", 64'(rd_req), 64'd0);
      tick();
    end
    checkOutput("t2_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checkOutput("t2_req_partial_room", 64'(rd_req), 64'd0);
    end
    tick();
    out_ready = 1'b0;
    checkOutput("t2_req_after_pops", 64'(rd_req), 64'd1);
    serveBurst(29'h220, 8'd16, 0, 1'b0, 1'b1, 16);
    checkOutput("t2_done", 64'(done), 64'd1);
    out_ready = 1'b1;
    waitDrain();
    checkOutput("t2_err", 64'(err), 64'd0);

    $display("[TB] test 3: zero-length command");
    req_seen = 1'b0;
    applyStimulus(29'h1234, 16'd0);
    checkOutput("t3_done", 64'(done), 64'd1);
    checkOutput("t3_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("t3_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("t3_done_once", 64'(done), 64'd0);
    repeat (3) tick();
    checkOutput("t3_no_req", 64'(req_seen), 64'd0);

    $display("[TB] test 4: address wrap");
    applyStimulus(29'h1FFFFFF0, 16'd24);
    serveBurst(29'h1FFFFFF0, 8'd16, 2, 1'b0, 1'b1, 16);
    serveBurst(29'h0000000, 8'd8, 2, 1'b0, 1'b1, 8);
    checkOutput("t4_done", 64'(done), 64'd1);
    waitDrain();

    $display("[TB] test 5: grant with data, then stray word");
    applyStimulus(29'h300, 16'd4);
    serveBurst(29'h300, 8'd4, 2, 1'b1, 1'b1, 4);
    checkOutput("t5_done", 64'(done), 64'd1);
    waitDrain();
    checkOutput("t5_err_clear", 64'(err), 64'd0);
    rd_data_valid = 1'b1;
    rd_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    rd_data_valid = 1'b0;
    checkOutput("t5_err_set", 64'(err), 64'd1);
    tick();
    checkOutput("t5_stray_dropped", 64'(out_valid), 64'd0);
    checkOutput("t5_err_sticky", 64'(err), 64'd1);

    $display("[TB] test 6: reset mid-burst");
    out_ready = 1'b0;
    applyStimulus(29'h400, 16'd32);
    serveBurst(29'h400, 8'd16, 1, 1'b0, 1'b0, 5);
    checkOutput("t6_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    checkResetValues("t6");
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    d0 = done_pulses;
    applyStimulus(29'h500, 16'd20);
    serveBurst(29'h500, 8'd16, 1, 1'b0, 1'b1, 16);
    serveBurst(29'h510, 8'd4, 1, 1'b0, 1'b1, 4);
    checkOutput("t6_done", 64'(done), 64'd1);
    waitDrain();
    checkOutput("t6_done_count", 64'(done_pulses - d0), 64'd1);
    checkOutput("t6_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
